wrapper_digest_capture_fifo: RTL

Parametrised capture-and-buffer stage between a hashing engine's result port and the AHB packet deconstructor in accelerator wrappers. It tracks message boundaries from the engine's input handshake and filters out intermediate per-block digests, either keeping only final-block digests or keeping all of them, selectable per instance. It buffers the kept results in a configurable-depth FIFO with valid/ready output. It also generates the DMA output data request and sticky error flags, because the engine result port has no backpressure.

---
 rtl/wrapper_digest_capture_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/wrapper_digest_capture_fifo.sv
// Capture stage between a hashing engine result port and the AHB packet deconstructor:
// tracks block boundaries in a tag queue, filters per-block digests and buffers kept ones.
module wrapper_digest_capture_fifo #(
   parameter int DATAWIDTH   = 256,
   parameter int DEPTH       = 4,
   parameter int TAGDEPTH    = 8,
   parameter int REMAINWIDTH = 6,
   parameter int KEEPALL     = 0
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic                         sync_rst,
   input  logic                         in_valid,
   input  logic                         in_ready,
   input  logic                         in_last,
   output logic                         in_gate,
   input  logic [DATAWIDTH-1:0]         digest,
   input  logic                         digest_valid,
   output logic [DATAWIDTH-1:0]         out_data,
   output logic                         out_last,
   output logic [REMAINWIDTH-1:0]       out_remain,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   out_count,
   output logic                         data_req,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int TAW = $clog2(TAGDEPTH);
   localparam int TPW = TAW + 1;

   logic [TPW-1:0]      twr_q, twr_d, trd_q, trd_d;
   logic [TAGDEPTH-1:0] tag_mem_q;
   logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [DATAWIDTH:0]  mem_q [DEPTH];
   logic                overflow_q, overflow_d, underflow_q, underflow_d;
   logic                tag_empty_s, tag_full_s, tag_push_s, tag_pop_s, tag_s, keep_s;
   logic                empty_s, full_s, push_s, pop_s;

   // Handshake decode, keep decision and next-state pointers/flags
   always_comb begin
      tag_empty_s = (twr_q == trd_q);
      tag_full_s  = (twr_q[TAW] != trd_q[TAW]) && (twr_q[TAW-1:0] == trd_q[TAW-1:0]);
      tag_pop_s   = digest_valid & ~tag_empty_s;
      in_gate     = ~tag_full_s | tag_pop_s;
      tag_push_s  = in_valid & in_ready & in_gate;
      // An orphan digest (no tag outstanding) is treated as a final-block digest
      tag_s       = tag_empty_s ? 1'b1 : tag_mem_q[trd_q[TAW-1:0]];
      keep_s      = digest_valid & ((KEEPALL != 0) | tag_s);
      empty_s     = (wr_q == rd_q);
      full_s      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop_s       = ~empty_s & out_ready;
      push_s      = keep_s & (~full_s | pop_s);
      twr_d       = tag_push_s ? twr_q + TPW'(1) : twr_q;
      trd_d       = tag_pop_s  ? trd_q + TPW'(1) : trd_q;
      wr_d        = push_s ? wr_q + PW'(1) : wr_q;
      rd_d        = pop_s  ? rd_q + PW'(1) : rd_q;
      overflow_d  = overflow_q | (keep_s & full_s & ~pop_s);
      underflow_d = underflow_q | (digest_valid & tag_empty_s);
      if (sync_rst) begin
         twr_d       = '0;
         trd_d       = '0;
         wr_d        = '0;
         rd_d        = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         twr_d = twr_d;
      end
   end

   // Pointers, tag storage and sticky flags
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         twr_q       <= '0;
         trd_q       <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         tag_mem_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         twr_q       <= twr_d;
         trd_q       <= trd_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         if (tag_push_s && !sync_rst) begin
            tag_mem_q[twr_q[TAW-1:0]] <= in_last;
         end
      end
   end

   // Digest storage; contents are qualified by the pointers so need no reset
   always_ff @(posedge HCLK) begin
      if (push_s && !sync_rst) begin
         mem_q[wr_q[AW-1:0]] <= {digest, tag_s};
      end
   end

   // Head of FIFO is read combinationally; out_last is masked while empty
   always_comb begin
      out_valid  = ~empty_s;
      data_req   = ~empty_s;
      out_data   = mem_q[rd_q[AW-1:0]][DATAWIDTH:1];
      out_last   = ~empty_s & mem_q[rd_q[AW-1:0]][0];
      out_count  = wr_q - rd_q;
      out_remain = '0;
      overflow   = overflow_q;
      underflow  = underflow_q;
   end

endmodule
